adpll_acq_sequencer: RTL and testbench

Acquisition and lock controller for the ring-oscillator ADPLL. Runs in the fpga_clk_i domain and samples the ADPLL phase error once per reference period. After reset it drives the DCO control code through a successive-approximation coarse search, then hands control to the loop filter. It reports lock status and re-runs acquisition on timeout.

---
 rtl/adpll_acq_sequencer.sv | 238 +++++++++++++++++++++++
 tb/tb_adpll_acq_sequencer.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/adpll_acq_sequencer.sv
// rtl/adpll_acq_sequencer.sv - ADPLL acquisition and lock sequencer
//
// Purpose: runs a successive-approximation coarse search on the DCO control
// code, once per reference tick, then hands the code to the loop filter and
// tracks lock. If TRACK runs too long without locking, the search restarts.
//
// Optional feature macro: ADPLL_SEQ_STATS_EN adds relock_cnt_o.
//
// Ports:
//   fpga_clk_i     sole clock
//   reset_i        synchronous active-high reset
//   enable_i       sequencer enable; low forces IDLE
//   ref_clk_i      reference clock, sampled as data
//   error_i        signed phase error, positive means the DCO is slow
//   dco_cc_o       signed coarse DCO code (the loop filter seed in TRACK)
//   cc_override_o  high while the sequencer owns the DCO code
//   loop_en_o      loop filter enable
//   locked_o       lock indicator
//   lock_lost_o    one-cycle pulse when lock drops
//   state_o        current state encoding
//   relock_cnt_o   saturating count of lock losses and timeouts (stats only)
module adpll_acq_sequencer #(
    parameter int unsigned SETTLE_REFS   = 4,
    parameter int unsigned LOCK_THRESH   = 3,
    parameter int unsigned LOCK_COUNT    = 16,
    parameter int unsigned UNLOCK_THRESH = 12,
    parameter int unsigned UNLOCK_COUNT  = 4,
    parameter int unsigned TRACK_TIMEOUT = 1023
) (
    input  logic       fpga_clk_i,
    input  logic       reset_i,
    input  logic       enable_i,
    input  logic       ref_clk_i,
    input  logic [7:0] error_i,
    output logic [4:0] dco_cc_o,
    output logic       cc_override_o,
    output logic       loop_en_o,
    output logic       locked_o,
    output logic       lock_lost_o,
`ifdef ADPLL_SEQ_STATS_EN
    output logic [7:0] relock_cnt_o,
`endif
    output logic [2:0] state_o
);

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_SETTLE       = 3'd1;
    localparam logic [2:0] ST_COARSE       = 3'd2;
    localparam logic [2:0] ST_SETTLE_FINAL = 3'd3;
    localparam logic [2:0] ST_TRACK        = 3'd4;
    localparam logic [2:0] ST_LOCKED       = 3'd5;

    // Reference synchroniser and rising-edge detect
    logic ref_meta, ref_sync, ref_dly;
    logic tick;
    assign tick = ref_sync & ~ref_dly;

    // Magnitude of the error; -128 has no positive 8-bit twin, so clamp it
    logic [7:0] err_abs;
    always_comb begin
        if (error_i == 8'h80)
            err_abs = 8'd127;
        else if (error_i[7])
            err_abs = -error_i;
        else
            err_abs = error_i;
    end

    logic       err_good, err_bad;
    assign err_good = (err_abs <= 8'(LOCK_THRESH));
    assign err_bad  = (err_abs >  8'(UNLOCK_THRESH));

    logic [2:0] state, state_nxt;
    logic [3:0] step, step_nxt;
    logic [4:0] cc_nxt;
    logic [7:0] settle_cnt, settle_nxt;
    logic [7:0] lock_cnt, lock_nxt;
    logic [7:0] exc_cnt, exc_nxt;
    logic [9:0] to_cnt, to_nxt;
    logic       lost_evt, timeout_evt;
    logic       override_nxt, loop_en_nxt, locked_nxt, lock_lost_nxt;

    assign state_o = state;

    // State and datapath register
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i) begin
            ref_meta      <= 1'b0;
            ref_sync      <= 1'b0;
            ref_dly       <= 1'b0;
            state         <= ST_IDLE;
            step          <= 4'd8;
            dco_cc_o      <= 5'd0;
            settle_cnt    <= 8'd0;
            lock_cnt      <= 8'd0;
            exc_cnt       <= 8'd0;
            to_cnt        <= 10'd0;
            cc_override_o <= 1'b1;
            loop_en_o     <= 1'b0;
            locked_o      <= 1'b0;
            lock_lost_o   <= 1'b0;
        end else begin
            ref_meta      <= ref_clk_i;
            ref_sync      <= ref_meta;
            ref_dly       <= ref_sync;
            state         <= state_nxt;
            step          <= step_nxt;
            dco_cc_o      <= cc_nxt;
            settle_cnt    <= settle_nxt;
            lock_cnt      <= lock_nxt;
            exc_cnt       <= exc_nxt;
            to_cnt        <= to_nxt;
            cc_override_o <= override_nxt;
            loop_en_o     <= loop_en_nxt;
            locked_o      <= locked_nxt;
            lock_lost_o   <= lock_lost_nxt;
        end
    end

    // Next-state and datapath update
    always_comb begin
        state_nxt   = state;
        step_nxt    = step;
        cc_nxt      = dco_cc_o;
        settle_nxt  = settle_cnt;
        lock_nxt    = lock_cnt;
        exc_nxt     = exc_cnt;
        to_nxt      = to_cnt;
        lost_evt    = 1'b0;
        timeout_evt = 1'b0;

        case (state)
            ST_IDLE: begin
                cc_nxt   = 5'd0;
                step_nxt = 4'd8;
                if (enable_i)
                    state_nxt = ST_SETTLE;
            end
            ST_SETTLE, ST_SETTLE_FINAL: begin
                if (tick) begin
                    if (settle_cnt == 8'(SETTLE_REFS - 1))
                        state_nxt = (state == ST_SETTLE) ? ST_COARSE : ST_TRACK;
                    else
                        settle_nxt = settle_cnt + 8'd1;
                end
            end
            ST_COARSE: begin
                if (tick) begin
                    if ($signed(error_i) > 0)
                        cc_nxt = dco_cc_o + {1'b0, step};
                    else if ($signed(error_i) < 0)
                        cc_nxt = dco_cc_o - {1'b0, step};
                    step_nxt  = step >> 1;
                    state_nxt = (step == 4'd1) ? ST_SETTLE_FINAL : ST_SETTLE;
                end
            end
            ST_TRACK: begin
                if (tick) begin
                    to_nxt   = to_cnt + 10'd1;
                    lock_nxt = err_good ? lock_cnt + 8'd1 : 8'd0;
                    if (err_good && lock_cnt == 8'(LOCK_COUNT - 1)) begin
                        state_nxt = ST_LOCKED;
                    end else if (to_cnt == 10'(TRACK_TIMEOUT - 1)) begin
                        // Give up on this code and restart the coarse search
                        state_nxt   = ST_SETTLE;
                        cc_nxt      = 5'd0;
                        step_nxt    = 4'd8;
                        timeout_evt = 1'b1;
                    end
                end
            end
            ST_LOCKED: begin
                if (tick) begin
                    if (err_bad) begin
                        if (exc_cnt == 8'(UNLOCK_COUNT - 1)) begin
                            state_nxt = ST_TRACK;
                            lost_evt  = 1'b1;
                        end else begin
                            exc_nxt = exc_cnt + 8'd1;
                        end
                    end else begin
                        exc_nxt = 8'd0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase

        // Every state entry starts its counters from zero
        if (state_nxt != state) begin
            settle_nxt = 8'd0;
            lock_nxt   = 8'd0;
            exc_nxt    = 8'd0;
            to_nxt     = 10'd0;
        end

        // Disable overrides everything, including a coincident tick
        if (!enable_i) begin
            state_nxt   = ST_IDLE;
            step_nxt    = 4'd8;
            cc_nxt      = 5'd0;
            settle_nxt  = 8'd0;
            lock_nxt    = 8'd0;
            exc_nxt     = 8'd0;
            to_nxt      = 10'd0;
            lost_evt    = 1'b0;
            timeout_evt = 1'b0;
        end
    end

    // Registered control outputs, derived from the state being entered
    always_comb begin
        override_nxt  = 1'b1;
        loop_en_nxt   = 1'b0;
        locked_nxt    = 1'b0;
        lock_lost_nxt = lost_evt;
        if (state_nxt == ST_TRACK || state_nxt == ST_LOCKED) begin
            override_nxt = 1'b0;
            loop_en_nxt  = 1'b1;
        end
        if (state_nxt == ST_LOCKED)
            locked_nxt = 1'b1;
    end

`ifdef ADPLL_SEQ_STATS_EN
    // Survives enable_i; only reset_i clears it
    always_ff @(posedge fpga_clk_i) begin
        if (reset_i)
            relock_cnt_o <= 8'd0;
        else if ((lost_evt || timeout_evt) && relock_cnt_o != 8'hFF)
            relock_cnt_o <= relock_cnt_o + 8'd1;
    end
`else
    logic unused_stats;
    assign unused_stats = timeout_evt;
`endif

endmodule

// File: tb/tb_adpll_acq_sequencer.sv
// tb/tb_adpll_acq_sequencer.sv - directed self-checking bench for adpll_acq_sequencer
`timescale 1ns/1ps
module tb_adpll_acq_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       enable = 1'b0;
    logic       ref_clk = 1'b0;
    logic [7:0] err = 8'd0;
    logic [4:0] dco_cc;
    logic       cc_override, loop_en, locked, lock_lost;
    logic [2:0] state;
`ifdef ADPLL_SEQ_STATS_EN
    logic [7:0] relock_cnt;
`endif

    int n_pass  = 0;
    int n_total = 0;
    int lost_cnt = 0;

    adpll_acq_sequencer dut (
        .fpga_clk_i   (clk),
        .reset_i      (reset),
        .enable_i     (enable),
        .ref_clk_i    (ref_clk),
        .error_i      (err),
        .dco_cc_o     (dco_cc),
        .cc_override_o(cc_override),
        .loop_en_o    (loop_en),
        .locked_o     (locked),
        .lock_lost_o  (lock_lost),
`ifdef ADPLL_SEQ_STATS_EN
        .relock_cnt_o (relock_cnt),
`endif
        .state_o      (state)
    );

    always #2 clk = ~clk;

    // Counts every cycle lock_lost is high, so a two-cycle pulse shows as 2
    always @(posedge clk)
        if (lock_lost === 1'b1)
            lost_cnt <= lost_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
    endtask

    function automatic logic [31:0] sx_cc(input logic [4:0] v);
        return {{27{v[4]}}, v};
    endfunction

    // One reference period per iteration: 4 cycles high, 4 low
    task automatic ref_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            ref_clk = 1'b1;
            repeat (4) @(negedge clk);
            ref_clk = 1'b0;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_state"}, 32'(state), 32'd0);
        chk({tag, "_cc"}, sx_cc(dco_cc), 32'd0);
        chk({tag, "_ovr"}, 32'(cc_override), 32'd1);
        chk({tag, "_loop"}, 32'(loop_en), 32'd0);
        chk({tag, "_lock"}, 32'(locked), 32'd0);
        chk({tag, "_lost"}, 32'(lock_lost), 32'd0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk_idle("reset");
`ifdef ADPLL_SEQ_STATS_EN
        chk("reset_relock", 32'(relock_cnt), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);
        chk("idle_no_enable", 32'(state), 32'd0);

        // Coarse search upward, error +20
        err = 8'd20;
        enable = 1'b1;
        @(negedge clk);
        chk("enter_settle", 32'(state), 32'd1);
        ref_ticks(4);
        chk("settle_to_coarse", 32'(state), 32'd2);
        chk("coarse_cc0", sx_cc(dco_cc), 32'd0);
        ref_ticks(1);
        chk("up_cc8", sx_cc(dco_cc), 32'd8);
        chk("up_back_settle", 32'(state), 32'd1);
        ref_ticks(5);
        chk("up_cc12", sx_cc(dco_cc), 32'd12);
        ref_ticks(5);
        chk("up_cc14", sx_cc(dco_cc), 32'd14);
        ref_ticks(5);
        chk("up_cc15", sx_cc(dco_cc), 32'd15);
        chk("up_settle_final", 32'(state), 32'd3);
        chk("up_sf_ovr", 32'(cc_override), 32'd1);
        ref_ticks(4);
        chk("up_track", 32'(state), 32'd4);
        chk("up_track_cc", sx_cc(dco_cc), 32'd15);
        chk("up_track_ovr", 32'(cc_override), 32'd0);
        chk("up_track_loop", 32'(loop_en), 32'd1);

        // Lock acquisition with a restart at tick 10
        err = 8'd2;
        ref_ticks(9);
        err = 8'd4;
        ref_ticks(1);
        err = 8'd2;
        ref_ticks(14);
        err = 8'hFD;                // -3, on the threshold
        ref_ticks(1);
        chk("lock_15_good", 32'(state), 32'd4);
        chk("lock_15_unlocked", 32'(locked), 32'd0);
        err = 8'd3;
        ref_ticks(1);
        chk("lock_16_state", 32'(state), 32'd5);
        chk("lock_16_locked", 32'(locked), 32'd1);

        // Excursion handling in LOCKED
        err = 8'd12;
        ref_ticks(5);
        chk("exc_at_thresh", 32'(state), 32'd5);
        err = 8'd13;
        ref_ticks(3);
        err = 8'd0;
        ref_ticks(1);
        chk("exc_3_then_good", 32'(locked), 32'd1);
        chk("exc_3_no_pulse", 32'(lost_cnt), 32'd0);
        err = 8'd13;
        ref_ticks(4);
        chk("lost_pulse_1cyc", 32'(lost_cnt), 32'd1);
        chk("lost_unlocked", 32'(locked), 32'd0);
        chk("lost_state_track", 32'(state), 32'd4);
        chk("lost_loop_en", 32'(loop_en), 32'd1);
`ifdef ADPLL_SEQ_STATS_EN
        chk("lost_relock", 32'(relock_cnt), 32'd1);
`endif

        // TRACK timeout after 1023 ticks
        err = 8'd50;
        ref_ticks(1022);
        chk("timeout_1022", 32'(state), 32'd4);
        ref_ticks(1);
        chk("timeout_state", 32'(state), 32'd1);
        chk("timeout_cc", sx_cc(dco_cc), 32'd0);
        chk("timeout_ovr", 32'(cc_override), 32'd1);
        chk("timeout_loop", 32'(loop_en), 32'd0);
`ifdef ADPLL_SEQ_STATS_EN
        chk("timeout_relock", 32'(relock_cnt), 32'd2);
`endif

        // Coarse search downward, error -5
        err = 8'hFB;
        ref_ticks(5);
        chk("dn_cc_m8", sx_cc(dco_cc), -32'sd8);
        ref_ticks(5);
        chk("dn_cc_m12", sx_cc(dco_cc), -32'sd12);
        ref_ticks(5);
        chk("dn_cc_m14", sx_cc(dco_cc), -32'sd14);
        ref_ticks(5);
        chk("dn_cc_m15", sx_cc(dco_cc), -32'sd15);
        ref_ticks(4);
        chk("dn_track", 32'(state), 32'd4);
        chk("dn_track_cc", sx_cc(dco_cc), -32'sd15);
        err = 8'h80;
        ref_ticks(20);
        chk("m128_no_lock_state", 32'(state), 32'd4);
        chk("m128_no_lock", 32'(locked), 32'd0);

        // Enable dropped in TRACK, then mid-COARSE
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("dis_track");
        @(negedge clk);
        enable = 1'b1;
        err = 8'd20;
        @(negedge clk);
        ref_ticks(5);
        chk("re_cc8", sx_cc(dco_cc), 32'd8);
        ref_ticks(4);
        chk("re_coarse", 32'(state), 32'd2);
        enable = 1'b0;
        @(posedge clk);
        #1;
        chk_idle("dis_coarse");
        @(negedge clk);

        // Reset while LOCKED
        enable = 1'b1;
        @(negedge clk);
        ref_ticks(24);
        err = 8'd0;
        ref_ticks(16);
        chk("relock_state", 32'(state), 32'd5);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk_idle("rst_locked");
        @(negedge clk);
        chk("rst_no_pulse", 32'(lost_cnt), 32'd1);
`ifdef ADPLL_SEQ_STATS_EN
        chk("rst_relock", 32'(relock_cnt), 32'd0);
`endif
        reset = 1'b0;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
